// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and helpers for the D-stage hazard scoreboard.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
package hazard_scoreboard_pkg;

  localparam int DEF_STAGES = 3;
  localparam int DEF_REG_AW = 5;
  localparam int DEF_TNEW_W = 2;
  localparam int DEF_DATA_W = 32;
  localparam int FWD_GRF    = 0;
  localparam int CNT_W      = 32;

  // All-ones Tuse/Tnew code: the operand is never read.
  function automatic int tuse_never(input int w);
    return (1 << w) - 1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_fwd_pick.sv
// Youngest-match search over the in-flight writer entries for one source operand.
// Purely combinational; instantiated once per operand (rs, rt).
module hazard_fwd_pick
  import hazard_scoreboard_pkg::*;
#(
  parameter int STAGES = DEF_STAGES,
  parameter int REG_AW = DEF_REG_AW,
  parameter int TNEW_W = DEF_TNEW_W,
  parameter int SEL_W  = $clog2(DEF_STAGES + 1)
) (
  input  logic [STAGES-1:0]        ent_v,
  input  logic [STAGES*REG_AW-1:0] ent_a3,
  input  logic [STAGES*TNEW_W-1:0] ent_tnew,
  input  logic [REG_AW-1:0]        op,
  input  logic [TNEW_W-1:0]        tuse,
  output logic                     hit,
  output logic [SEL_W-1:0]         idx,
  output logic [TNEW_W-1:0]        tnew
);

  localparam logic [TNEW_W-1:0] TUSE_NEVER = TNEW_W'(tuse_never(TNEW_W));

  logic [STAGES-1:0] match;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_match
      assign match[gi] = ent_v[gi] && (ent_a3[gi*REG_AW +: REG_AW] == op);
    end
  endgenerate

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    tnew = '0;
    if ((op != '0) && (tuse != TUSE_NEVER)) begin
      for (int k = STAGES - 1; k >= 0; k--) begin
        if (match[k]) begin
          hit  = 1'b1;
          idx  = SEL_W'(k);
          tnew = ent_tnew[k*TNEW_W +: TNEW_W];
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage hazard unit: tracks in-flight GRF writers, raises stall, picks D-stage forwards.
// Define HAZARD_PERF_CNT_EN to add the saturating stall_cnt/fwd_cnt outputs.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int STAGES = DEF_STAGES,
  parameter int REG_AW = DEF_REG_AW,
  parameter int TNEW_W = DEF_TNEW_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          d_valid,
  input  logic [REG_AW-1:0]             d_rs,
  input  logic [REG_AW-1:0]             d_rt,
  input  logic [TNEW_W-1:0]             d_tuse_rs,
  input  logic [TNEW_W-1:0]             d_tuse_rt,
  input  logic                          d_we,
  input  logic [REG_AW-1:0]             d_a3,
  input  logic [TNEW_W-1:0]             d_tnew,
  input  logic                          d_md_flag,
  input  logic                          md_busy,
  input  logic                          flush,
  input  logic [STAGES*DATA_W-1:0]      stage_data,
  input  logic [DATA_W-1:0]             rf_rs_data,
  input  logic [DATA_W-1:0]             rf_rt_data,
  output logic                          stall,
  output logic [$clog2(STAGES+1)-1:0]   fwd_rs_sel,
  output logic [$clog2(STAGES+1)-1:0]   fwd_rt_sel,
  output logic [DATA_W-1:0]             fwd_rs_data,
  output logic [DATA_W-1:0]             fwd_rt_data
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]              stall_cnt,
  output logic [CNT_W-1:0]              fwd_cnt
`endif
);

  localparam int SEL_W = $clog2(STAGES + 1);

  logic [STAGES-1:0]        v_q, v_d;
  logic [STAGES*REG_AW-1:0] a3_q, a3_d;
  logic [STAGES*TNEW_W-1:0] tnew_q, tnew_d;

  logic              rs_hit, rt_hit;
  logic [SEL_W-1:0]  rs_idx, rt_idx;
  logic [TNEW_W-1:0] rs_tnew, rt_tnew;
  logic              rs_stall, rt_stall, md_stall;

  hazard_fwd_pick #(.STAGES(STAGES), .REG_AW(REG_AW), .TNEW_W(TNEW_W), .SEL_W(SEL_W)) u_pick_rs (
    .ent_v(v_q), .ent_a3(a3_q), .ent_tnew(tnew_q),
    .op(d_rs), .tuse(d_tuse_rs),
    .hit(rs_hit), .idx(rs_idx), .tnew(rs_tnew)
  );

  hazard_fwd_pick #(.STAGES(STAGES), .REG_AW(REG_AW), .TNEW_W(TNEW_W), .SEL_W(SEL_W)) u_pick_rt (
    .ent_v(v_q), .ent_a3(a3_q), .ent_tnew(tnew_q),
    .op(d_rt), .tuse(d_tuse_rt),
    .hit(rt_hit), .idx(rt_idx), .tnew(rt_tnew)
  );

  // Gating with reset makes stall drop the instant reset is asserted.
  always_comb begin
    rs_stall    = rs_hit && (rs_tnew > d_tuse_rs);
    rt_stall    = rt_hit && (rt_tnew > d_tuse_rt);
    md_stall    = d_md_flag && md_busy;
    stall       = reset && d_valid && (rs_stall || rt_stall || md_stall);
    fwd_rs_sel  = SEL_W'(FWD_GRF);
    fwd_rt_sel  = SEL_W'(FWD_GRF);
    fwd_rs_data = rf_rs_data;
    fwd_rt_data = rf_rt_data;
    if (rs_hit && (rs_tnew == '0)) begin
      fwd_rs_sel  = rs_idx + 1'b1;
      fwd_rs_data = stage_data[rs_idx*DATA_W +: DATA_W];
    end
    if (rt_hit && (rt_tnew == '0)) begin
      fwd_rt_sel  = rt_idx + 1'b1;
      fwd_rt_data = stage_data[rt_idx*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    v_d    = v_q;
    a3_d   = a3_q;
    tnew_d = tnew_q;
    for (int k = STAGES - 1; k >= 1; k--) begin
      v_d[k]                        = v_q[k-1];
      a3_d[k*REG_AW +: REG_AW]      = a3_q[(k-1)*REG_AW +: REG_AW];
      tnew_d[k*TNEW_W +: TNEW_W]    = (tnew_q[(k-1)*TNEW_W +: TNEW_W] == '0) ? '0 :
                                      tnew_q[(k-1)*TNEW_W +: TNEW_W] - 1'b1;
    end
    v_d[0]            = !stall && d_valid && d_we && (d_a3 != '0);
    a3_d[REG_AW-1:0]  = d_a3;
    tnew_d[TNEW_W-1:0] = d_tnew;
    if (flush) begin
      v_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q    <= '0;
      a3_q   <= '0;
      tnew_q <= '0;
    end else begin
      v_q    <= v_d;
      a3_q   <= a3_d;
      tnew_q <= tnew_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;

  always_comb begin
    stall_cnt_d = sat_inc(stall_cnt_q, stall);
    fwd_cnt_d   = sat_inc(fwd_cnt_q, !stall && ((fwd_rs_sel != '0) || (fwd_rt_sel != '0)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule
